scalar_memory: RTL and testbench

SCALAR_MEMORY -- requirements
Module: scalar_memory

---
 rtl/scalar_memory_pkg.sv | 13 +
 rtl/scalar_memory.sv | 141 ++++++++++++++
 tb/tb_scalar_memory.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/scalar_memory_pkg.sv
// Shared definitions for the scalar pipeline stages: default widths and the
// memory-stage FSM state encoding.
package scalar_memory_pkg;

    localparam int unsigned SCALAR_DATA_W = 36;
    localparam int unsigned SCALAR_REG_W  = 5;

    typedef enum logic {
        MEM_IDLE,
        MEM_BUSY
    } mem_state_e;

endpackage

// File: rtl/scalar_memory.sv
// Scalar memory stage: forwards ALU results to writeback or issues a single
// outstanding data-cache load/store, stalling upstream until it completes.
module scalar_memory
    import scalar_memory_pkg::*;
#(
    parameter int unsigned DATA_W = SCALAR_DATA_W,
    parameter int unsigned REG_W  = SCALAR_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_wb_en,
    input  logic [REG_W-1:0]  ex_wb_reg,
    input  logic              flush,
    output logic              mem_stall,
    output logic              dc_req,
    output logic              dc_we,
    output logic [DATA_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_wdata,
    input  logic              dc_ack,
    input  logic [DATA_W-1:0] dc_rdata,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data
);

    mem_state_e        state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              req_wb_en_q, req_wb_en_d;
    logic [REG_W-1:0]  req_wb_reg_q, req_wb_reg_d;
    logic              flushed_q, flushed_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_en_q, wb_en_d;
    logic [REG_W-1:0]  wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic accept;
    logic is_mem_op;

    assign mem_stall = (state_q == MEM_BUSY);
    assign accept    = ex_valid && !mem_stall && !flush;
    assign is_mem_op = ex_mem_read || ex_mem_write;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        req_wb_en_d  = req_wb_en_q;
        req_wb_reg_d = req_wb_reg_q;
        flushed_d    = flushed_q;
        wb_valid_d   = 1'b0;
        wb_en_d      = wb_en_q;
        wb_reg_d     = wb_reg_q;
        wb_data_d    = wb_data_q;

        unique case (state_q)
            MEM_IDLE: begin
                if (accept) begin
                    if (is_mem_op) begin
                        state_d      = MEM_BUSY;
                        addr_d       = ex_alu_result;
                        wdata_d      = ex_store_data;
                        // A read wins when both selects are high.
                        we_d         = ex_mem_write && !ex_mem_read;
                        req_wb_en_d  = ex_wb_en;
                        req_wb_reg_d = ex_wb_reg;
                        flushed_d    = 1'b0;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_en_d    = ex_wb_en;
                        wb_reg_d   = ex_wb_reg;
                        wb_data_d  = ex_alu_result;
                    end
                end
            end
            MEM_BUSY: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (dc_ack) begin
                    state_d   = MEM_IDLE;
                    flushed_d = 1'b0;
                    // Flushed requests still drain but leave no writeback.
                    if (!flushed_q && !flush) begin
                        wb_valid_d = 1'b1;
                        wb_en_d    = we_q ? 1'b0 : req_wb_en_q;
                        wb_reg_d   = req_wb_reg_q;
                        wb_data_d  = we_q ? '0 : dc_rdata;
                    end
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= MEM_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            req_wb_en_q  <= 1'b0;
            req_wb_reg_q <= '0;
            flushed_q    <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_reg_q     <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            req_wb_en_q  <= req_wb_en_d;
            req_wb_reg_q <= req_wb_reg_d;
            flushed_q    <= flushed_d;
            wb_valid_q   <= wb_valid_d;
            wb_en_q      <= wb_en_d;
            wb_reg_q     <= wb_reg_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign dc_req   = mem_stall;
    assign dc_we    = mem_stall && we_q;
    assign dc_addr  = addr_q;
    assign dc_wdata = wdata_q;
    assign wb_valid = wb_valid_q;
    assign wb_en    = wb_en_q;
    assign wb_reg   = wb_reg_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_scalar_memory.sv
// Directed bench for scalar_memory: ALU pass-through, loads, stores, flush,
// asynchronous reset mid-request and back-to-back issue.
module tb_scalar_memory;

    localparam int unsigned DATA_W = 36;
    localparam int unsigned REG_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_store_data;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_wb_en;
    logic [REG_W-1:0]  ex_wb_reg;
    logic              flush;
    logic              mem_stall;
    logic              dc_req;
    logic              dc_we;
    logic [DATA_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_ack;
    logic [DATA_W-1:0] dc_rdata;
    logic              wb_valid;
    logic              wb_en;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    scalar_memory #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_wb_en(ex_wb_en), .ex_wb_reg(ex_wb_reg), .flush(flush),
        .mem_stall(mem_stall),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ack(dc_ack), .dc_rdata(dc_rdata),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_wb_en = 1'b0; ex_wb_reg = '0;
        flush = 1'b0; dc_ack = 1'b0; dc_rdata = '0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] sd, input logic en, input logic [REG_W-1:0] rg);
        ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
        ex_alu_result = alu; ex_store_data = sd; ex_wb_en = en; ex_wb_reg = rg;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) step();
        tests_run++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b want 0", mem_stall); end
        tests_run++; if (dc_req !== 1'b0 || dc_we !== 1'b0) begin fails++; $display("FAIL reset_dc: got req=%0b we=%0b want 0/0", dc_req, dc_we); end
        tests_run++; if (dc_addr !== '0 || dc_wdata !== '0) begin fails++; $display("FAIL reset_dc_bus: got %h/%h want 0/0", dc_addr, dc_wdata); end
        tests_run++; if ({wb_valid, wb_en, wb_reg, wb_data} !== '0) begin fails++; $display("FAIL reset_wb: got v=%0b en=%0b reg=%0d data=%h want all 0", wb_valid, wb_en, wb_reg, wb_data); end
        #2 rst = 1'b0;
        step();
    endtask

    task automatic test_alu();
        issue(1'b0, 1'b0, 36'h0_0000_1234, '0, 1'b1, 5'd3);
        step();
        ex_valid = 1'b0;
        tests_run++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL alu_wb_valid: got %0b want 1", wb_valid); end
        tests_run++; if (wb_data !== 36'h1234) begin fails++; $display("FAIL alu_wb_data: got %h want 1234", wb_data); end
        tests_run++; if (wb_reg !== 5'd3 || wb_en !== 1'b1) begin fails++; $display("FAIL alu_wb_reg: got reg=%0d en=%0b want 3/1", wb_reg, wb_en); end
        tests_run++; if (mem_stall !== 1'b0 || dc_req !== 1'b0) begin fails++; $display("FAIL alu_stall: got stall=%0b req=%0b want 0/0", mem_stall, dc_req); end
        step();
        tests_run++; if (wb_valid !== 1'b0 || wb_data !== 36'h1234) begin fails++; $display("FAIL alu_pulse: got v=%0b data=%h want 0/1234", wb_valid, wb_data); end
    endtask

    task automatic test_ack_idle();
        dc_ack = 1'b1; dc_rdata = 36'hF00D;
        step();
        dc_ack = 1'b0;
        tests_run++; if (wb_valid !== 1'b0 || mem_stall !== 1'b0) begin fails++; $display("FAIL ack_idle: got v=%0b stall=%0b want 0/0", wb_valid, mem_stall); end
    endtask

    task automatic test_load();
        issue(1'b1, 1'b0, 36'h100, 36'h999, 1'b1, 5'd7);
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (dc_req !== 1'b1 || mem_stall !== 1'b1 || dc_addr !== 36'h100 || dc_we !== 1'b0 || wb_valid !== 1'b0) begin
                fails++;
                $display("FAIL load_busy%0d: got req=%0b stall=%0b addr=%h we=%0b v=%0b want 1/1/100/0/0", i, dc_req, mem_stall, dc_addr, dc_we, wb_valid);
            end
            if (i == 2) begin dc_ack = 1'b1; dc_rdata = 36'hABCDE; end
            step();
        end
        dc_ack = 1'b0;
        tests_run++; if (dc_req !== 1'b0 || mem_stall !== 1'b0) begin fails++; $display("FAIL load_done_stall: got req=%0b stall=%0b want 0/0", dc_req, mem_stall); end
        tests_run++; if (wb_valid !== 1'b1 || wb_data !== 36'hABCDE) begin fails++; $display("FAIL load_wb: got v=%0b data=%h want 1/abcde", wb_valid, wb_data); end
        tests_run++; if (wb_en !== 1'b1 || wb_reg !== 5'd7) begin fails++; $display("FAIL load_wb_reg: got en=%0b reg=%0d want 1/7", wb_en, wb_reg); end
        step();
        tests_run++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL load_pulse: got %0b want 0", wb_valid); end
    endtask

    task automatic test_store();
        issue(1'b0, 1'b1, 36'h200, 36'h55, 1'b1, 5'd9);
        step();
        ex_valid = 1'b0;
        tests_run++; if (dc_req !== 1'b1 || dc_we !== 1'b1 || dc_addr !== 36'h200 || dc_wdata !== 36'h55) begin fails++; $display("FAIL store_req: got req=%0b we=%0b addr=%h wdata=%h want 1/1/200/55", dc_req, dc_we, dc_addr, dc_wdata); end
        dc_ack = 1'b1; dc_rdata = 36'h777;
        step();
        dc_ack = 1'b0;
        tests_run++; if (wb_valid !== 1'b1 || wb_en !== 1'b0 || wb_data !== '0) begin fails++; $display("FAIL store_wb: got v=%0b en=%0b data=%h want 1/0/0", wb_valid, wb_en, wb_data); end
        tests_run++; if (dc_req !== 1'b0 || dc_we !== 1'b0) begin fails++; $display("FAIL store_done: got req=%0b we=%0b want 0/0", dc_req, dc_we); end
        step();
    endtask

    task automatic test_read_write_both();
        issue(1'b1, 1'b1, 36'h300, 36'h66, 1'b1, 5'd4);
        step();
        ex_valid = 1'b0;
        tests_run++; if (dc_req !== 1'b1 || dc_we !== 1'b0) begin fails++; $display("FAIL both_we: got req=%0b we=%0b want 1/0", dc_req, dc_we); end
        dc_ack = 1'b1; dc_rdata = 36'h12345;
        step();
        dc_ack = 1'b0;
        tests_run++; if (wb_valid !== 1'b1 || wb_data !== 36'h12345 || wb_en !== 1'b1) begin fails++; $display("FAIL both_wb: got v=%0b data=%h en=%0b want 1/12345/1", wb_valid, wb_data, wb_en); end
        step();
    endtask

    task automatic test_flush_busy();
        issue(1'b1, 1'b0, 36'h400, '0, 1'b1, 5'd5);
        step();
        ex_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        tests_run++; if (dc_req !== 1'b1 || dc_addr !== 36'h400 || mem_stall !== 1'b1) begin fails++; $display("FAIL flush_hold: got req=%0b addr=%h stall=%0b want 1/400/1", dc_req, dc_addr, mem_stall); end
        dc_ack = 1'b1; dc_rdata = 36'hBAD;
        step();
        dc_ack = 1'b0;
        tests_run++; if (wb_valid !== 1'b0 || mem_stall !== 1'b0) begin fails++; $display("FAIL flush_wb: got v=%0b stall=%0b want 0/0", wb_valid, mem_stall); end
        step();
        tests_run++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL flush_wb_late: got %0b want 0", wb_valid); end
    endtask

    task automatic test_flush_with_ack();
        issue(1'b1, 1'b0, 36'h500, '0, 1'b1, 5'd6);
        step();
        ex_valid = 1'b0; flush = 1'b1; dc_ack = 1'b1; dc_rdata = 36'hBEEF;
        step();
        flush = 1'b0; dc_ack = 1'b0;
        tests_run++; if (wb_valid !== 1'b0 || mem_stall !== 1'b0 || dc_req !== 1'b0) begin fails++; $display("FAIL flush_ack: got v=%0b stall=%0b req=%0b want 0/0/0", wb_valid, mem_stall, dc_req); end
    endtask

    task automatic test_reset_busy();
        issue(1'b1, 1'b0, 36'h600, '0, 1'b1, 5'd8);
        step();
        ex_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++; if (dc_req !== 1'b0 || mem_stall !== 1'b0 || dc_addr !== '0) begin fails++; $display("FAIL rst_busy: got req=%0b stall=%0b addr=%h want 0/0/0", dc_req, mem_stall, dc_addr); end
        #1 rst = 1'b0;
        dc_ack = 1'b1; dc_rdata = 36'hDEAD;
        step();
        dc_ack = 1'b0;
        tests_run++; if (wb_valid !== 1'b0 || mem_stall !== 1'b0) begin fails++; $display("FAIL rst_late_ack: got v=%0b stall=%0b want 0/0", wb_valid, mem_stall); end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 1'b0, 36'h700, '0, 1'b1, 5'd10);
        step();
        issue(1'b0, 1'b0, 36'h4242, '0, 1'b1, 5'd11);
        tests_run++; if (mem_stall !== 1'b1 || wb_valid !== 1'b0) begin fails++; $display("FAIL b2b_stall: got stall=%0b v=%0b want 1/0", mem_stall, wb_valid); end
        dc_ack = 1'b1; dc_rdata = 36'h777;
        step();
        dc_ack = 1'b0;
        tests_run++; if (wb_valid !== 1'b1 || wb_data !== 36'h777 || wb_reg !== 5'd10 || mem_stall !== 1'b0) begin fails++; $display("FAIL b2b_load: got v=%0b data=%h reg=%0d stall=%0b want 1/777/10/0", wb_valid, wb_data, wb_reg, mem_stall); end
        step();
        ex_valid = 1'b0;
        tests_run++; if (wb_valid !== 1'b1 || wb_data !== 36'h4242 || wb_reg !== 5'd11) begin fails++; $display("FAIL b2b_alu: got v=%0b data=%h reg=%0d want 1/4242/11", wb_valid, wb_data, wb_reg); end
        step();
        tests_run++; if (wb_valid !== 1'b0 || wb_data !== 36'h4242) begin fails++; $display("FAIL b2b_end: got v=%0b data=%h want 0/4242", wb_valid, wb_data); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ack_idle();
        test_load();
        test_store();
        test_read_write_both();
        test_flush_busy();
        test_flush_with_ack();
        test_reset_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
